// File: rtl/seq_array_multiplier_if.sv
// Valid/ready operand and result channels of the sequential array multiplier.
// The producer/consumer side uses the master modport, the multiplier uses slave.
interface seq_array_multiplier_if #(
    parameter int WIDTH = 8
);
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic                   is_signed;
    logic                   out_valid;
    logic                   out_ready;
    logic [2*WIDTH-1:0]     product;
    logic                   busy;

    modport master (
        output in_valid, a, b, is_signed, out_ready,
        input  in_ready, out_valid, product, busy
    );

    modport slave (
        input  in_valid, a, b, is_signed, out_ready,
        output in_ready, out_valid, product, busy
    );
endinterface

// File: rtl/seq_array_multiplier.sv
// Iterative WIDTH x WIDTH shift-add multiplier, one partial-product row per clock.
// Signed operations run on magnitudes; the sign is applied once on the last row.
module seq_array_multiplier #(
    parameter int WIDTH      = 8,
    parameter int EARLY_EXIT = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    seq_array_multiplier_if.slave  bus
);
    localparam int PW    = 2 * WIDTH;
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam bit   EE_ON = (EARLY_EXIT != 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [WIDTH-1:0]     r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [PW-1:0]        r_acc;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_neg;
    logic [PW-1:0]        r_product;
    logic                 r_in_ready;
    logic                 r_out_valid;
    logic                 r_busy;

    logic                 w_accept;
    logic [PW-1:0]        w_addend;
    logic [PW-1:0]        w_acc_sum;
    logic [WIDTH-1:0]     w_mplier_shr;
    logic                 w_calc_last;
    logic [PW-1:0]        w_result;

    // -2^(W-1) maps to 2^(W-1), which still fits the unsigned W-bit magnitude
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic s);
        if (s && v[WIDTH-1]) begin
            return ~v + WIDTH'(1);
        end else begin
            return v;
        end
    endfunction

    assign w_accept = (r_state == S_IDLE) && bus.in_valid && r_in_ready;

    // One partial-product row and the exit decision for the current CALC edge
    always_comb begin
        w_addend     = {PW{1'b0}};
        w_acc_sum    = {PW{1'b0}};
        w_mplier_shr = {WIDTH{1'b0}};
        w_calc_last  = 1'b0;
        w_result     = {PW{1'b0}};
        if (r_mplier[0]) begin
            w_addend = {{WIDTH{1'b0}}, r_mcand} << r_cnt;
        end else begin
            w_addend = {PW{1'b0}};
        end
        w_acc_sum    = r_acc + w_addend;
        w_mplier_shr = r_mplier >> 1'b1;
        w_calc_last  = (r_cnt == LAST_CNT) || (EE_ON && (w_mplier_shr == {WIDTH{1'b0}}));
        if (r_neg) begin
            w_result = ~w_acc_sum + PW'(1);
        end else begin
            w_result = w_acc_sum;
        end
    end

    // Next-state logic of the IDLE -> CALC -> DONE controller
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = S_CALC;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_CALC: begin
                if (w_calc_last) begin
                    w_state_next = S_DONE;
                end else begin
                    w_state_next = S_CALC;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_state_next = S_DONE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Controller state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Datapath and registered handshake outputs, decoded from the next state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mcand     <= {WIDTH{1'b0}};
            r_mplier    <= {WIDTH{1'b0}};
            r_acc       <= {PW{1'b0}};
            r_cnt       <= {CNT_W{1'b0}};
            r_neg       <= 1'b0;
            r_product   <= {PW{1'b0}};
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_in_ready  <= (w_state_next == S_IDLE);
            r_out_valid <= (w_state_next == S_DONE);
            r_busy      <= (w_state_next == S_CALC) || (w_state_next == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_mcand  <= magnitude(bus.a, bus.is_signed);
                        r_mplier <= magnitude(bus.b, bus.is_signed);
                        r_neg    <= bus.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        r_acc    <= {PW{1'b0}};
                        r_cnt    <= {CNT_W{1'b0}};
                    end
                end
                S_CALC: begin
                    r_acc    <= w_acc_sum;
                    r_mplier <= w_mplier_shr;
                    r_cnt    <= r_cnt + CNT_W'(1);
                    if (w_calc_last) begin
                        r_product <= w_result;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.busy      = r_busy;
    assign bus.product   = r_product;
endmodule

// File: tb/tb_seq_array_multiplier.sv
// Bench for seq_array_multiplier: three instances (8-bit, 4-bit, 8-bit early exit)
// checked every cycle against a latency/arithmetic model, plus directed literals.
module tb_seq_array_multiplier;
    logic clk;
    logic rst_n;

    seq_array_multiplier_if #(.WIDTH(8)) if8 ();
    seq_array_multiplier_if #(.WIDTH(4)) if4 ();
    seq_array_multiplier_if #(.WIDTH(8)) ife ();

    seq_array_multiplier #(.WIDTH(8), .EARLY_EXIT(0)) u8m (.clk(clk), .rst_n(rst_n), .bus(if8));
    seq_array_multiplier #(.WIDTH(4), .EARLY_EXIT(0)) u4m (.clk(clk), .rst_n(rst_n), .bus(if4));
    seq_array_multiplier #(.WIDTH(8), .EARLY_EXIT(1)) uem (.clk(clk), .rst_n(rst_n), .bus(ife));

    // bench-side drive and observation, indexed 0 = 8-bit, 1 = 4-bit, 2 = early exit
    logic       iv [3];
    logic [7:0] ia [3];
    logic [7:0] ib [3];
    logic       is [3];
    logic       ordy [3];
    logic [2:0] rdy_o;
    logic [2:0] vld_o;
    logic [2:0] bsy_o;
    logic [15:0] prod [3];

    assign if8.in_valid = iv[0];   assign if4.in_valid = iv[1];      assign ife.in_valid = iv[2];
    assign if8.a = ia[0];          assign if4.a = ia[1][3:0];        assign ife.a = ia[2];
    assign if8.b = ib[0];          assign if4.b = ib[1][3:0];        assign ife.b = ib[2];
    assign if8.is_signed = is[0];  assign if4.is_signed = is[1];     assign ife.is_signed = is[2];
    assign if8.out_ready = ordy[0]; assign if4.out_ready = ordy[1];  assign ife.out_ready = ordy[2];
    assign rdy_o = {ife.in_ready, if4.in_ready, if8.in_ready};
    assign vld_o = {ife.out_valid, if4.out_valid, if8.out_valid};
    assign bsy_o = {ife.busy, if4.busy, if8.busy};
    assign prod[0] = if8.product;
    assign prod[1] = {8'h00, if4.product};
    assign prod[2] = ife.product;

    int total = 0;
    int bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: bound expired", name);
    endtask

    function automatic int width_of(input int k);
        return (k == 1) ? 4 : 8;
    endfunction

    // Reference product: plain integer multiply of the W-bit operands, truncated to 2W bits
    function automatic logic [15:0] ref_product(input int w, input logic [7:0] a,
                                                input logic [7:0] b, input bit s);
        longint sa, sb, p, mask;
        mask = (longint'(1) << w) - 1;
        sa = longint'(a) & mask;
        sb = longint'(b) & mask;
        if (s && sa >= (longint'(1) << (w - 1))) sa = sa - (longint'(1) << w);
        if (s && sb >= (longint'(1) << (w - 1))) sb = sb - (longint'(1) << w);
        p = sa * sb;
        return 16'(p & ((longint'(1) << (2 * w)) - 1));
    endfunction

    // Reference latency in edges from accept to out_valid
    function automatic int ref_latency(input int w, input bit ee, input logic [7:0] b, input bit s);
        longint mag;
        int msb;
        if (!ee) return w;
        mag = longint'(b) & ((longint'(1) << w) - 1);
        if (s && mag >= (longint'(1) << (w - 1))) mag = (longint'(1) << w) - mag;
        if (mag == 0) return 1;
        msb = 0;
        for (int i = 0; i < w; i++) if (((mag >> i) & 1) == 1) msb = i;
        return msb + 1;
    endfunction

    // behavioural model state
    int          m_cnt [3];
    logic        m_valid [3];
    logic        m_rdy [3];
    logic [15:0] m_prod [3];
    logic [15:0] m_exp [3];
    logic        m_live = 1'b0;

    // model update on every rising edge
    always @(posedge clk) begin
        if (!rst_n) m_live <= 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                m_cnt[k] <= 0; m_valid[k] <= 1'b0; m_rdy[k] <= 1'b0; m_prod[k] <= 16'h0000;
            end else if (m_valid[k]) begin
                if (ordy[k]) begin
                    m_valid[k] <= 1'b0; m_rdy[k] <= 1'b1;
                end
            end else if (m_cnt[k] != 0) begin
                m_cnt[k] <= m_cnt[k] - 1;
                if (m_cnt[k] == 1) begin
                    m_valid[k] <= 1'b1; m_prod[k] <= m_exp[k];
                end
            end else if (!m_rdy[k]) begin
                m_rdy[k] <= 1'b1;
            end else if (iv[k]) begin
                m_exp[k] <= ref_product(width_of(k), ia[k], ib[k], is[k]);
                m_cnt[k] <= ref_latency(width_of(k), k == 2, ib[k], is[k]);
                m_rdy[k] <= 1'b0;
            end
        end
    end

    // compare all outputs of all instances against the model each cycle
    always @(negedge clk) begin
        if (m_live) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("k%0d in_ready", k), 32'(rdy_o[k]), 32'(m_rdy[k]));
                chk($sformatf("k%0d out_valid", k), 32'(vld_o[k]), 32'(m_valid[k]));
                chk($sformatf("k%0d busy", k), 32'(bsy_o[k]), 32'((m_cnt[k] != 0) || m_valid[k]));
                chk($sformatf("k%0d product", k), 32'(prod[k]), 32'(m_prod[k]));
            end
        end
    end

    // one operation; exp_p / exp_lat < 0 leave checking to the model
    task automatic do_op(input int k, input logic [7:0] a, input logic [7:0] b, input bit s,
                         input int stall, input int exp_p, input int exp_lat);
        int n;
        bit got;
        @(negedge clk);
        n = 0;
        while (rdy_o[k] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) fail_now("wait in_ready");
        ordy[k] = (stall == 0);
        iv[k] = 1'b1; ia[k] = a; ib[k] = b; is[k] = s;
        @(posedge clk);
        #1;
        iv[k] = 1'b0; ia[k] = ~a; ib[k] = a ^ 8'h5A; is[k] = ~s;
        n = 0;
        got = 1'b0;
        while (!got && n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (vld_o[k] === 1'b1) got = 1'b1;
        end
        if (!got) begin
            fail_now("wait out_valid");
        end else begin
            if (exp_lat >= 0) chk($sformatf("latency a=%0h b=%0h", a, b), 32'(n), 32'(exp_lat));
            if (exp_p >= 0) chk($sformatf("product a=%0h b=%0h", a, b), 32'(prod[k]), 32'(exp_p));
            if (stall > 0) begin
                repeat (stall) @(posedge clk);
                #1;
                chk("held out_valid", 32'(vld_o[k]), 32'd1);
                if (exp_p >= 0) chk("held product", 32'(prod[k]), 32'(exp_p));
                @(negedge clk);
                ordy[k] = 1'b1;
            end
            @(posedge clk);
            #1;
            chk("out_valid drop", 32'(vld_o[k]), 32'd0);
            chk("in_ready back", 32'(rdy_o[k]), 32'd1);
            ordy[k] = 1'b0;
        end
    endtask

    initial begin
        int seen;
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            iv[k] = 1'b0; ia[k] = 8'h00; ib[k] = 8'h00; is[k] = 1'b0; ordy[k] = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("reset in_ready", 32'(rdy_o[0]), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle in_ready", 32'(rdy_o[0]), 32'd1);
        chk("idle out_valid", 32'(vld_o[0]), 32'd0);
        chk("idle busy", 32'(bsy_o[0]), 32'd0);
        chk("idle product", 32'(prod[0]), 32'd0);

        chk("ref 4b F*F unsigned", 32'(ref_product(4, 8'h0F, 8'h0F, 1'b0)), 32'd225);
        chk("ref 4b F*F signed", 32'(ref_product(4, 8'h0F, 8'h0F, 1'b1)), 32'd1);
        chk("ref 8b FD*7 signed", 32'(ref_product(8, 8'hFD, 8'h07, 1'b1)), 32'h0000FFEB);
        chk("ref ee lat b=80", 32'(ref_latency(8, 1'b1, 8'h80, 1'b0)), 32'd8);

        do_op(0, 8'd200, 8'd150, 1'b0, 0, 30000, 8);
        do_op(0, 8'h80, 8'h80, 1'b1, 5, 16'h4000, 8);
        do_op(0, 8'hFD, 8'd7, 1'b1, 5, 16'hFFEB, 8);
        do_op(0, 8'h7F, 8'h80, 1'b1, 0, 16'hC080, 8);

        do_op(1, 8'h0F, 8'h0F, 1'b0, 0, 225, 4);
        do_op(1, 8'h0F, 8'h0F, 1'b1, 0, 1, 4);
        for (int s = 0; s < 2; s++)
            for (int a = 0; a < 16; a++)
                for (int b = 0; b < 16; b++)
                    do_op(1, 8'(a), 8'(b), s[0], 0, -1, -1);

        do_op(2, 8'd99, 8'd1, 1'b0, 0, 99, 1);
        do_op(2, 8'd55, 8'd0, 1'b1, 0, 0, 1);
        do_op(2, 8'd3, 8'h80, 1'b0, 0, 384, 8);
        do_op(2, 8'd5, 8'hFF, 1'b1, 2, 16'hFFFB, 1);
        do_op(2, 8'd10, 8'd12, 1'b0, 0, 120, 4);

        // reset on the 4th CALC edge of an 8-bit op
        @(negedge clk);
        iv[0] = 1'b1; ia[0] = 8'd77; ib[0] = 8'd91; is[0] = 1'b0; ordy[0] = 1'b1;
        @(posedge clk);
        #1;
        iv[0] = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mid reset busy", 32'(bsy_o[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (vld_o[0] === 1'b1) seen++;
        end
        chk("no result after reset", 32'(seen), 32'd0);
        ordy[0] = 1'b0;
        do_op(0, 8'd5, 8'd6, 1'b0, 0, 30, 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/seq_array_multiplier.md
Name: seq_array_multiplier

Overview:
- Parametrised, iterative successor to the fixed 4x4 combinational array multiplier.
- Computes a WIDTH x WIDTH product, one partial-product row per clock, in a shift-add datapath.
- Supports an unsigned or signed (two's-complement) mode per operation and an optional early exit.
- Sits between a valid/ready producer and a valid/ready consumer in the arithmetic datapath.

Parameters:
- WIDTH, 8: operand width in bits; legal range 2..32. The product is 2*WIDTH bits.
- EARLY_EXIT, 0: when 1, the CALC state ends as soon as the remaining multiplier bits are all zero.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operands a, b and is_signed are valid
- in_ready  output  1  block can accept operands; high only in IDLE
- a  input  WIDTH  multiplicand
- b  input  WIDTH  multiplier
- is_signed  input  1  1 = two's-complement operation, 0 = unsigned
- out_valid  output  1  product holds a valid result
- out_ready  input  1  consumer accepts the result
- product  output  2*WIDTH  result, held stable while out_valid=1
- busy  output  1  high in CALC or DONE

Behaviour:
- Reset: rst_n is sampled low on a rising clk edge. Reset effects:
  - state goes to IDLE and the in-flight operation is discarded;
  - in_ready=0 during the reset cycle, then 1 in IDLE;
  - out_valid=0, busy=0, product=0; accumulator and counter are cleared.
- Reset mid-CALC or mid-DONE follows the same rules, and no result is ever emitted for the discarded operation.
- State machine:
  - IDLE: in_ready=1. The accept edge is any edge with in_valid=1. On it:
    - capture mcand = |a| (if is_signed=1) or a;
    - capture mplier = |b| (if is_signed=1) or b;
    - capture neg = is_signed & (a[W-1] ^ b[W-1]);
    - clear the accumulator and set cnt=0;
    - go to CALC.
  - CALC: each edge performs:
    - acc = acc + (mplier[0] ? mcand<<cnt : 0), in 2*WIDTH bits;
    - mplier >>= 1;
    - cnt++.
  - CALC exit: leave after the edge where cnt reaches WIDTH-1. If EARLY_EXIT=1, also leave after any edge where the shifted mplier becomes 0. On exit:
    - product = neg ? -acc_final : acc_final (2*WIDTH-bit two's complement);
    - go to DONE.
  - DONE: out_valid=1 and product is held. An edge with out_ready=1 causes out_valid=0 and a return to IDLE. With out_ready=0, the block holds indefinitely.
- Latency, EARLY_EXIT=0: out_valid rises exactly WIDTH edges after the accept edge.
- Latency, EARLY_EXIT=1: out_valid rises 1 + index of the highest set bit of |b| edges after the accept edge. If b=0, out_valid rises 1 edge after the accept edge.
- Throughput: no overlap between operations. in_ready stays 0 from the accept edge until the edge after the out_ready handshake. The minimum initiation interval is WIDTH+2 cycles.
- Magnitude of the most-negative operand:
  - -2^(W-1) is held as the unsigned value 2^(W-1) in W bits; no overflow.
  - The product always fits in 2*WIDTH bits. (-2^(W-1))^2 = 2^(2W-2) is a positive result.
- Unsigned mode ignores the sign bits entirely.
- Zero operand: the result is 0 and neg is irrelevant, because -0 = 0.
- Inputs a, b and is_signed are ignored outside the accept edge. Changing them during CALC has no effect.
- out_ready outside DONE is ignored.
- product changes only on the CALC->DONE edge or on reset. After the DONE->IDLE handshake, product keeps its last value, and out_valid=0 marks it stale.

Test Plan:
- Reset then idle, WIDTH=8, EARLY_EXIT=0: rst_n=0 for 2 cycles, then 1 -> in_ready=1, out_valid=0, busy=0, product=0.
- Unsigned multiply: a=8'd200, b=8'd150, is_signed=0, out_ready=1 -> out_valid exactly 8 edges after accept, product=16'd30000, return to IDLE next edge.
- Signed corner cases, is_signed=1. Each result is held until out_ready is raised after 5 stall cycles.
  - a=8'h80, b=8'h80 -> product=16'h4000.
  - a=8'hFD (-3), b=8'd7 -> product=16'hFFEB (-21).
- Exhaustive check, WIDTH=4: all 256 (a,b) pairs in both modes are compared against a reference model. This includes 4'hF x 4'hF: unsigned 8'd225, signed 8'd1.
- Early exit, EARLY_EXIT=1, WIDTH=8:
  - b=8'd1, a=8'd99 -> out_valid 1 edge after accept, product=99.
  - b=8'd0 -> out_valid 1 edge after accept, product=0.
  - b=8'h80 -> out_valid 8 edges after accept.
- Reset mid-operation: assert rst_n=0 on the 4th CALC edge -> next cycle IDLE, out_valid never asserts for that op. A new op a=5, b=6 then yields product=30.
